// File: rtl/memory_responder.sv
// memory_responder: big-endian byte-array memory behind a four-phase
// MOV/MOC handshake with configurable wait states and alignment checking.
module memory_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        DataType,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              ERR
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte always legal; halfword needs even address; word needs 4-byte alignment.
  function automatic logic is_legal(input logic [1:0] dtype, input logic [1:0] lsb);
    logic ok;
    case (dtype)
      2'b00:   ok = 1'b1;
      2'b01:   ok = (lsb[0] == 1'b0);
      2'b10:   ok = (lsb == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               rw_q, rw_d;
  logic [1:0]         dt_q, dt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        dout_q, dout_d;
  logic               moc_q, moc_d;
  logic               err_q, err_d;

  logic [7:0]         mem [DEPTH];
  logic               mem_we_s;
  logic               legal_s;
  logic [ADDR_W-1:0]  a1_s, a2_s, a3_s;
  logic [31:0]        rdata_s;

  assign a1_s    = addr_q + ADDR_W'(1);
  assign a2_s    = addr_q + ADDR_W'(2);
  assign a3_s    = addr_q + ADDR_W'(3);
  assign legal_s = is_legal(dt_q, addr_q[1:0]);

  // Assemble zero-extended big-endian read data for the latched request.
  always_comb begin
    rdata_s = 32'h0;
    case (dt_q)
      2'b00:   rdata_s = {24'h0, mem[addr_q]};
      2'b01:   rdata_s = {16'h0, mem[addr_q], mem[a1_s]};
      2'b10:   rdata_s = {mem[addr_q], mem[a1_s], mem[a2_s], mem[a3_s]};
      default: rdata_s = 32'h0;
    endcase
  end

  // Next-state and output logic of the handshake FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    dt_d     = dt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    moc_d    = moc_q;
    err_d    = err_q;
    mem_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MOV) begin
          rw_d    = RW;
          dt_d    = DataType;
          addr_d  = Address;
          wdata_d = DataIn;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          moc_d   = 1'b1;
          if (legal_s) begin
            err_d = 1'b0;
            if (rw_q) begin
              dout_d = rdata_s;
            end else begin
              mem_we_s = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (!MOV) begin
          moc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        moc_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // Control and output registers; the byte array itself is not reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      dt_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      dout_q  <= 32'h0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      dt_q    <= dt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
    end
  end

  // Array write on the WAIT->DONE edge of a legal write, big-endian lanes.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      case (dt_q)
        2'b00: begin
          mem[addr_q] <= wdata_q[7:0];
        end
        2'b01: begin
          mem[addr_q] <= wdata_q[15:8];
          mem[a1_s]   <= wdata_q[7:0];
        end
        default: begin
          mem[addr_q] <= wdata_q[31:24];
          mem[a1_s]   <= wdata_q[23:16];
          mem[a2_s]   <= wdata_q[15:8];
          mem[a3_s]   <= wdata_q[7:0];
        end
      endcase
    end
  end

  assign DataOut = dout_q;
  assign MOC     = moc_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: two instances (2 and 0 wait states) share one
// request stream; a transaction-level model predicts MOC/ERR/DataOut per cycle.
module tb_memory_responder;

  localparam int AW = 8;
  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mov = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  dt = 2'b00;
  logic [7:0]  addr = 8'h00;
  logic [31:0] din = 32'h0;
  logic [31:0] dout [2];
  logic        moc [2];
  logic        err [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_responder #(.ADDR_W(AW), .WAIT_CYCLES(W0)) u_dut (
    .clk(clk), .reset_n(reset_n), .MOV(mov), .RW(rw), .DataType(dt),
    .Address(addr), .DataIn(din), .DataOut(dout[0]), .MOC(moc[0]), .ERR(err[0])
  );

  memory_responder #(.ADDR_W(AW), .WAIT_CYCLES(W1)) u_dut_w0 (
    .clk(clk), .reset_n(reset_n), .MOV(mov), .RW(rw), .DataType(dt),
    .Address(addr), .DataIn(din), .DataOut(dout[1]), .MOC(moc[1]), .ERR(err[1])
  );

  // ---------------- reference model (transaction level) ----------------
  int          wait_of [2];
  logic [7:0]  mem_m [2][256];
  logic        m_moc [2];
  logic        m_err [2];
  logic [31:0] m_dout [2];
  bit          m_pend [2];
  bit          m_done [2];
  int          m_due [2];
  logic        m_rw [2];
  logic [1:0]  m_dt [2];
  logic [7:0]  m_a [2];
  logic [31:0] m_d [2];
  int          edge_no = 0;
  bit          cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_finish(input int i);
    bit          legal;
    int          n;
    logic [31:0] v;
    legal = (m_dt[i] == 2'b00) ||
            (m_dt[i] == 2'b01 && m_a[i][0] == 1'b0) ||
            (m_dt[i] == 2'b10 && m_a[i][1:0] == 2'b00);
    n = 1 << m_dt[i];
    if (!legal) begin
      m_err[i] = 1'b1;
    end else begin
      m_err[i] = 1'b0;
      if (m_rw[i]) begin
        v = 32'h0;
        for (int b = 0; b < n; b++) v = (v << 8) | 32'(mem_m[i][int'(m_a[i]) + b]);
        m_dout[i] = v;
      end else begin
        for (int b = 0; b < n; b++)
          mem_m[i][int'(m_a[i]) + b] = 8'(m_d[i] >> (8 * (n - 1 - b)));
      end
    end
    m_moc[i]  = 1'b1;
    m_done[i] = 1'b1;
    m_pend[i] = 1'b0;
  endtask

  // Model update: a request accepted at edge k completes at edge k+W+1.
  initial begin
    wait_of[0] = W0;
    wait_of[1] = W1;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int i = 0; i < 2; i++) begin
          m_moc[i] = 1'b0; m_err[i] = 1'b0; m_dout[i] = 32'h0;
          m_pend[i] = 1'b0; m_done[i] = 1'b0; m_due[i] = 0;
        end
      end else begin
        edge_no++;
        for (int i = 0; i < 2; i++) begin
          if (m_done[i]) begin
            if (!mov) begin
              m_done[i] = 1'b0; m_moc[i] = 1'b0; m_err[i] = 1'b0;
            end
          end else if (m_pend[i]) begin
            if (edge_no == m_due[i]) model_finish(i);
          end else if (mov) begin
            m_pend[i] = 1'b1;
            m_due[i]  = edge_no + wait_of[i] + 1;
            m_rw[i] = rw; m_dt[i] = dt; m_a[i] = addr; m_d[i] = din;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("moc_cyc%0d", i), {31'b0, moc[i]}, {31'b0, m_moc[i]});
          chk($sformatf("err_cyc%0d", i), {31'b0, err[i]}, {31'b0, m_err[i]});
          chk($sformatf("dout_cyc%0d", i), dout[i], m_dout[i]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // mode 0: normal; mode 1: drop MOV during WAIT; mode 2: hold MOV after MOC.
  // Request fields are scrambled after acceptance; the DUT must ignore that.
  task automatic access(input logic r, input logic [1:0] t, input logic [7:0] a,
                        input logic [31:0] d, input int mode,
                        output logic [31:0] rd, output logic re);
    int n, n0, n1;
    mov = 1'b1; rw = r; dt = t; addr = a; din = d;
    n = 0; n0 = 0; n1 = 0; rd = 32'h0; re = 1'b0;
    while (n0 == 0 && n < 40) begin
      @(posedge clk); #1; n++;
      if (moc[1] && n1 == 0) n1 = n;
      if (moc[0] && n0 == 0) begin
        n0 = n; rd = dout[0]; re = err[0];
      end
      if (n == 1) begin
        rw = 1'($urandom); dt = 2'($urandom); addr = 8'($urandom); din = $urandom;
        if (mode == 1) mov = 1'b0;
      end
    end
    if (n0 == 0) begin
      chk("moc_timeout", 32'(n), 32'(W0 + 2));
      mov = 1'b0;
      @(posedge clk); #1;
    end else begin
      chk("latency_w2", 32'(n0), 32'(W0 + 2));
      chk("latency_w0", 32'(n1), 32'(W1 + 2));
      if (mode == 2) begin
        repeat (3) begin
          @(posedge clk); #1;
          chk("moc_held", {31'b0, moc[0]}, 32'h1);
        end
      end
      mov = 1'b0;
      @(posedge clk); #1;
      chk("moc_fall_w2", {31'b0, moc[0]}, 32'h0);
      chk("moc_fall_w0", {31'b0, moc[1]}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    logic [31:0] rdv;
    logic        rev;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    cmp_on = 1'b1;
    chk("reset_dout", dout[0], 32'h0);
    chk("reset_moc", {31'b0, moc[0]}, 32'h0);
    chk("reset_err", {31'b0, err[0]}, 32'h0);

    // Prefill the working region so every later read is defined.
    for (int a = 0; a < 64; a += 4) access(1'b0, 2'b10, 8'(a), $urandom, 0, rdv, rev);

    // Reset during WAIT of a word write drops the write.
    access(1'b0, 2'b10, 8'h10, 32'h0, 0, rdv, rev);
    mov = 1'b1; rw = 1'b0; dt = 2'b10; addr = 8'h10; din = 32'hDEADBEEF;
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1;
    mov = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_mid_moc%0d", i), {31'b0, moc[i]}, 32'h0);
      chk($sformatf("rst_mid_err%0d", i), {31'b0, err[i]}, 32'h0);
      chk($sformatf("rst_mid_dout%0d", i), dout[i], 32'h0);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    access(1'b1, 2'b10, 8'h10, 32'h0, 0, rdv, rev);
    chk("aborted_write_rd", rdv, 32'h0);

    // Word / byte / halfword accesses.
    access(1'b0, 2'b10, 8'h20, 32'h11223344, 0, rdv, rev);
    access(1'b1, 2'b10, 8'h20, 32'h0, 0, rdv, rev);
    chk("word_rd", rdv, 32'h11223344);
    chk("word_rd_err", {31'b0, rev}, 32'h0);
    access(1'b1, 2'b00, 8'h21, 32'h0, 0, rdv, rev);
    chk("byte_rd", rdv, 32'h00000022);
    access(1'b1, 2'b01, 8'h22, 32'h0, 0, rdv, rev);
    chk("half_rd", rdv, 32'h00003344);
    access(1'b0, 2'b00, 8'h23, 32'h000000AB, 0, rdv, rev);
    access(1'b1, 2'b10, 8'h20, 32'h0, 0, rdv, rev);
    chk("byte_wr_rd", rdv, 32'h112233AB);

    // Illegal accesses.
    access(1'b1, 2'b10, 8'h21, 32'h0, 0, rdv, rev);
    chk("mis_word_err", {31'b0, rev}, 32'h1);
    chk("mis_word_dout", rdv, 32'h112233AB);
    access(1'b0, 2'b01, 8'h23, 32'h0000FFFF, 0, rdv, rev);
    chk("mis_half_err", {31'b0, rev}, 32'h1);
    access(1'b1, 2'b11, 8'h20, 32'h0, 0, rdv, rev);
    chk("dt11_err", {31'b0, rev}, 32'h1);
    access(1'b1, 2'b10, 8'h20, 32'h0, 0, rdv, rev);
    chk("after_illegal_rd", rdv, 32'h112233AB);

    // Handshake corners.
    access(1'b0, 2'b10, 8'h24, 32'h0, 0, rdv, rev);
    access(1'b0, 2'b00, 8'h24, 32'h00000055, 1, rdv, rev);
    access(1'b1, 2'b10, 8'h24, 32'h0, 0, rdv, rev);
    chk("drop_wait_wr", rdv, 32'h55000000);
    access(1'b0, 2'b10, 8'h28, 32'hCAFEF00D, 2, rdv, rev);
    access(1'b1, 2'b10, 8'h28, 32'h0, 0, rdv, rev);
    chk("hold_wr", rdv, 32'hCAFEF00D);

    // Randomised traffic, back-to-back or with idle gaps.
    repeat (80) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 63)),
             $urandom, $urandom_range(0, 2), rdv, rev);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
